// File: rtl/seg_scan_controller.sv
// seg_scan_controller: two-digit seven-segment scan controller with blanking gaps,
// hex decode to active-low cathodes and a once-per-frame input snapshot.
module seg_scan_controller #(
  parameter int TICK_DIV    = 100000,
  parameter int ON_TICKS    = 4,
  parameter int BLANK_TICKS = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [3:0] digit0_val,
  input  logic [3:0] digit1_val,
  output logic       a0,
  output logic       a1,
  output logic [6:0] cathode,
  output logic       frame_done
);
  localparam int PW   = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int DMAX = ON_TICKS > BLANK_TICKS ? ON_TICKS : BLANK_TICKS;
  localparam int DW   = DMAX > 1 ? $clog2(DMAX) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] ON_LAST = DW'(ON_TICKS - 1);
  localparam logic [DW-1:0] BL_LAST = DW'(BLANK_TICKS > 0 ? BLANK_TICKS - 1 : 0);
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  typedef enum logic [1:0] {DIG0, BLANK0, DIG1, BLANK1} state_t;
  state_t          r_state, w_state_nx;
  logic [PW-1:0]   r_presc, w_presc_nx;
  logic [DW-1:0]   r_dwell, w_dwell_nx;
  logic [3:0]      r_snap0, r_snap1, w_snap0_nx, w_snap1_nx;
  logic            r_snap_en, w_snap_en_nx;
  logic            w_tick, w_dig, w_last, w_frame, w_a0_nx, w_a1_nx;
  logic [6:0]      w_cath_nx;
  always_comb begin
    w_tick       = r_presc == P_LAST;
    w_dig        = r_state == DIG0 || r_state == DIG1;
    w_last       = w_tick && r_dwell == (w_dig ? ON_LAST : BL_LAST);
    w_state_nx   = !w_last ? r_state :
                   r_state == DIG0   ? (BLANK_TICKS > 0 ? BLANK0 : DIG1) :
                   r_state == BLANK0 ? DIG1 :
                   r_state == DIG1   ? (BLANK_TICKS > 0 ? BLANK1 : DIG0) : DIG0;
    w_frame      = w_last && w_state_nx == DIG0;
    w_presc_nx   = w_tick ? '0 : r_presc + 1'b1;
    w_dwell_nx   = !w_tick ? r_dwell : w_last ? '0 : r_dwell + 1'b1;
    w_snap0_nx   = w_frame ? digit0_val : r_snap0;
    w_snap1_nx   = w_frame ? digit1_val : r_snap1;
    w_snap_en_nx = w_frame ? enable : r_snap_en;
    // outputs are decoded from next-state values so they register on the state's edge
    w_a0_nx      = !(w_state_nx == DIG0 && w_snap_en_nx);
    w_a1_nx      = !(w_state_nx == DIG1 && w_snap_en_nx);
    w_cath_nx    = !w_a0_nx ? SEG_LUT[w_snap0_nx] : !w_a1_nx ? SEG_LUT[w_snap1_nx] : 7'h7F;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= BLANK1;
      r_presc    <= '0;
      r_dwell    <= '0;
      r_snap0    <= '0;
      r_snap1    <= '0;
      r_snap_en  <= 1'b0;
      a0         <= 1'b1;
      a1         <= 1'b1;
      cathode    <= 7'h7F;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_presc    <= w_presc_nx;
      r_dwell    <= w_dwell_nx;
      r_snap0    <= w_snap0_nx;
      r_snap1    <= w_snap1_nx;
      r_snap_en  <= w_snap_en_nx;
      a0         <= w_a0_nx;
      a1         <= w_a1_nx;
      cathode    <= w_cath_nx;
      frame_done <= w_frame;
    end
  end
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: randomized frame-level scoreboard for the scan controller,
// plus a no-blank instance checked against its own frame model.
module tb_seg_scan_controller;
  localparam int TD = 4, ON = 2, BL = 1;
  localparam int DC = TD * ON, BC = TD * BL, FL = 2 * (DC + BC);
  localparam int NF = 40, RF = 20;
  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic [3:0] digit0_val = '0, digit1_val = '0;
  logic a0, a1, frame_done, a0_2, a1_2, fd_2;
  logic [6:0] cathode, cath_2;
  logic [8:0] exp_q [$];
  logic [8:0] cur = '0, s2 = '0;
  logic [3:0] nd0, nd1;
  logic nen;
  int cyc = -4, c2 = -4, checks = 0, fails = 0;
  bit d0on, d1on, e0on, e1on;

  seg_scan_controller #(.TICK_DIV(TD), .ON_TICKS(ON), .BLANK_TICKS(BL)) dut (
    .clock(clk), .reset_n(reset_n), .enable(enable), .digit0_val(digit0_val),
    .digit1_val(digit1_val), .a0(a0), .a1(a1), .cathode(cathode), .frame_done(frame_done));
  seg_scan_controller #(.TICK_DIV(TD), .ON_TICKS(ON), .BLANK_TICKS(0)) dut_nb (
    .clock(clk), .reset_n(reset_n), .enable(enable), .digit0_val(digit0_val),
    .digit1_val(digit1_val), .a0(a0_2), .a1(a1_2), .cathode(cath_2), .frame_done(fd_2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic pick(input int f);
    nd0 = f < 16 ? 4'(f) : 4'($urandom);
    nd1 = f < 16 ? 4'(15 - f) : 4'($urandom);
    nen = f < 16 ? 1'b1 : (f == 16 || f == 17) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
    exp_q.push_back({nen, nd1, nd0});
  endtask

  task automatic do_reset(input int hold, input int f);
    reset_n = 1'b0;
    repeat (hold) begin @(negedge clk); #1; end
    pick(f);
    {enable, digit1_val, digit0_val} = {nen, nd1, nd0};
    reset_n = 1'b1;
    repeat (4) begin @(negedge clk); #1; end
  endtask

  // Monitor: position in the frame is derived from elapsed cycles since reset release;
  // the expected snapshot for each frame is popped when that frame starts.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_a0", a0, 1); chk("rst_a1", a1, 1);
      chk("rst_cathode", cathode, 7'h7F); chk("rst_frame_done", frame_done, 0);
      chk("rst_nb_anodes", {a0_2, a1_2, fd_2}, 3'b110);
      exp_q.delete();
      cyc = -4;
      c2 = -4;
    end else begin
      cyc = cyc + 1 == FL ? 0 : cyc + 1;
      c2 = c2 + 1 == 2 * DC ? 0 : c2 + 1;
      if (cyc == 0) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 0, 1);
        else cur = exp_q.pop_front();
      end
      if (c2 == 0) s2 = {enable, digit1_val, digit0_val};
      d0on = cyc >= 0 && cur[8] && cyc < DC;
      d1on = cyc >= DC + BC && cur[8] && cyc < 2 * DC + BC;
      chk("frame_done", frame_done, cyc == 0);
      chk("a0", a0, !d0on);
      chk("a1", a1, !d1on);
      chk("cathode", cathode, d0on ? SEG[cur[3:0]] : d1on ? SEG[cur[7:4]] : 7'h7F);
      e0on = c2 >= 0 && s2[8] && c2 < DC;
      e1on = c2 >= DC && s2[8];
      chk("nb_frame_done", fd_2, c2 == 0);
      chk("nb_a0", a0_2, !e0on);
      chk("nb_a1", a1_2, !e1on);
      chk("nb_cathode", cath_2, e0on ? SEG[s2[3:0]] : e1on ? SEG[s2[7:4]] : 7'h7F);
    end
    chk("anode_excl", a0 | a1, 1);
    chk("nb_anode_excl", a0_2 | a1_2, 1);
  end

  initial begin
    int kf;
    do_reset(3, 0);
    for (int f = 1; f < NF; f++) begin
      pick(f);
      kf = $urandom_range(0, FL - 1);
      for (int j = 0; j < FL; j++) begin
        if (f == RF && j == 14) break;
        {enable, digit1_val, digit0_val} = j >= kf ? {nen, nd1, nd0} : 9'($urandom);
        @(negedge clk); #1;
      end
      if (f == RF) do_reset(2, f);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
